// File: rtl/seanetnackgenerator_timer_queue_if.sv
// Timer write-request and alarm channels between the control core (master) and the timer queue (slave).
// Both channels: a transfer happens in a cycle with vld && rdy; a raised vld holds its data stable until then.
interface seanetnackgenerator_timer_queue_if #(
    parameter int TIMER_WIDTH = 512
);
    logic [TIMER_WIDTH-1:0] i_timer_wrreq;
    logic                   i_timer_wrreq_vld;
    logic                   o_timer_wrreq_rdy;
    logic [TIMER_WIDTH-1:0] o_timer_alarm;
    logic                   o_timer_alarm_vld;
    logic                   i_timer_alarm_rdy;

    modport master (
        output i_timer_wrreq,
        output i_timer_wrreq_vld,
        input  o_timer_wrreq_rdy,
        input  o_timer_alarm,
        input  o_timer_alarm_vld,
        output i_timer_alarm_rdy
    );

    modport slave (
        input  i_timer_wrreq,
        input  i_timer_wrreq_vld,
        output o_timer_wrreq_rdy,
        output o_timer_alarm,
        output o_timer_alarm_vld,
        input  i_timer_alarm_rdy
    );
endinterface

// File: rtl/seanetnackgenerator_timer_queue.sv
// Fixed-timeout timer queue: stamps each write with an expiry tick, releases FIFO head as an alarm once due.
// Optional macro TIMERQ_FORCE_EXPIRE_EN: i_cfg_reg0[1] forces every non-empty head to expire.
module seanetnackgenerator_timer_queue #(
    parameter int TIMER_WIDTH   = 512,
    parameter int DEPTH         = 64,
    parameter int TS_WIDTH      = 16,
    parameter int TICK_CYCLES   = 1024,
    parameter int TIMEOUT_TICKS = 100
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    seanetnackgenerator_timer_queue_if.slave tq,
    input  logic [31:0]                     i_cfg_reg0,
    output logic [31:0]                     o_sta_reg0,
    output logic [31:0]                     o_sta_reg1,
    output logic [31:0]                     o_sta_reg2,
    output logic [31:0]                     o_sta_reg3
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int EW = TIMER_WIDTH + TS_WIDTH;

    logic [PW-1:0]          pre_q, pre_d;
    logic [TS_WIDTH-1:0]    tick_q, tick_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [TIMER_WIDTH-1:0] alarm_q, alarm_d;
    logic                   alarm_vld_q, alarm_vld_d;
    logic                   clr_q, clr_d, force_q, force_d;
    logic [31:0]            wr_cnt_q, wr_cnt_d, al_cnt_q, al_cnt_d, stall_cnt_q, stall_cnt_d;

    logic [EW-1:0]          mem_q [DEPTH];
    logic [EW-1:0]          head;
    logic [TS_WIDTH-1:0]    age;
    logic                   wr_rdy, push, pop, eligible, delivered, stall;
    logic                   unused_cfg;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

`ifdef TIMERQ_FORCE_EXPIRE_EN
    assign force_d    = i_cfg_reg0[1];
    assign unused_cfg = ^i_cfg_reg0[31:2];
`else
    assign force_d    = 1'b0;
    assign unused_cfg = ^i_cfg_reg0[31:1];
`endif

    always_comb begin
        wr_rdy    = (count_q < (AW+1)'(DEPTH));
        push      = tq.i_timer_wrreq_vld && wr_rdy;
        stall     = tq.i_timer_wrreq_vld && !wr_rdy;
        head      = mem_q[rd_ptr_q];
        // Unsigned difference with MSB clear means the stamp has been reached, even across counter wrap.
        age       = tick_q - head[TS_WIDTH-1:0];
        eligible  = (count_q != '0) && (!age[TS_WIDTH-1] || force_q);
        pop       = eligible && (!alarm_vld_q || tq.i_timer_alarm_rdy);
        delivered = alarm_vld_q && tq.i_timer_alarm_rdy;

        pre_d  = pre_q + PW'(1);
        tick_d = tick_q;
        if (pre_q == PW'(TICK_CYCLES - 1)) begin
            pre_d  = '0;
            tick_d = tick_q + TS_WIDTH'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + (AW+1)'(1);
        if (!push && pop) count_d = count_q - (AW+1)'(1);

        alarm_d     = alarm_q;
        alarm_vld_d = alarm_vld_q;
        if (pop) begin
            alarm_d     = head[EW-1:TS_WIDTH];
            alarm_vld_d = 1'b1;
        end else if (tq.i_timer_alarm_rdy) begin
            alarm_vld_d = 1'b0;
        end

        clr_d       = i_cfg_reg0[0];
        wr_cnt_d    = clr_q ? '0 : sat_inc(wr_cnt_q, push);
        al_cnt_d    = clr_q ? '0 : sat_inc(al_cnt_q, delivered);
        stall_cnt_d = clr_q ? '0 : sat_inc(stall_cnt_q, stall);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            pre_q       <= '0;
            tick_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alarm_q     <= '0;
            alarm_vld_q <= 1'b0;
            clr_q       <= 1'b0;
            force_q     <= 1'b0;
            wr_cnt_q    <= '0;
            al_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            pre_q       <= pre_d;
            tick_q      <= tick_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            alarm_q     <= alarm_d;
            alarm_vld_q <= alarm_vld_d;
            clr_q       <= clr_d;
            force_q     <= force_d;
            wr_cnt_q    <= wr_cnt_d;
            al_cnt_q    <= al_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read as valid.
    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= {tq.i_timer_wrreq, tick_q + TS_WIDTH'(TIMEOUT_TICKS)};
    end

    assign tq.o_timer_wrreq_rdy = wr_rdy;
    assign tq.o_timer_alarm     = alarm_q;
    assign tq.o_timer_alarm_vld = alarm_vld_q;
    assign o_sta_reg0           = 32'(count_q);
    assign o_sta_reg1           = wr_cnt_q;
    assign o_sta_reg2           = al_cnt_q;
    assign o_sta_reg3           = stall_cnt_q;
endmodule
